approx_mult_engine: RTL and testbench

Parametrised successor to the fixed 16-bit RAM-driven approximate multiplier controller. It is a self-contained engine that merges controller and datapath. It reads N_PAIRS operand pairs from an external synchronous-read RAM and computes each product, either approximately (leading-one truncation to SEG_W bits) or exactly, selectable per run. It writes the 2*DATA_W-bit results to a second RAM port and signals completion to the top level.

---
 rtl/approx_mult_engine_pkg.sv | 32 +++
 rtl/approx_mult_engine_if.sv | 44 ++++
 rtl/approx_mult_engine_lod_normalizer.sv | 55 +++++
 rtl/approx_mult_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_approx_mult_engine.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mult_engine_pkg.sv
// Shared definitions for the approximate multiplier engine: state encoding,
// default derived widths and the helper that sizes the shift counters.
package approx_mult_engine_pkg;

    // Default operand width; instances with other widths derive their own
    // sizes through calc_sh_w().
    localparam int DEF_DATA_W = 16;

    // Shift-count width: must hold DATA_W-1 (the largest normalising shift).
    localparam int SH_W   = $clog2(DEF_DATA_W) + 1;
    // Exponent width: signed, spans -2*(DATA_W-1) .. 2*DATA_W.
    localparam int E_W    = SH_W + 2;
    // Product width.
    localparam int PROD_W = 2 * DEF_DATA_W;

    // FSM state encoding.
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_RD_A   = 4'd1;
    localparam logic [3:0] ST_RD_B   = 4'd2;
    localparam logic [3:0] ST_CAPT   = 4'd3;
    localparam logic [3:0] ST_NORM   = 4'd4;
    localparam logic [3:0] ST_MUL    = 4'd5;
    localparam logic [3:0] ST_DENORM = 4'd6;
    localparam logic [3:0] ST_WR     = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // Width of a shift counter able to count up to data_w-1.
    function automatic int calc_sh_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/approx_mult_engine_if.sv
// Control and RAM-port bundle of the approximate multiplier engine.
// master = engine side, slave = environment (RAM model / sequencer) side.
interface approx_mult_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic                  start;
    logic                  exact_mode;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [2*DATA_W-1:0]   wr_data;
    logic                  busy;
    logic                  done;

    modport master (
        input  start,
        input  exact_mode,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        output busy,
        output done
    );

    modport slave (
        output start,
        output exact_mode,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  busy,
        input  done
    );

endinterface

// File: rtl/approx_mult_engine_lod_normalizer.sv
// Leading-one normaliser for one operand: holds the operand, shifts it left
// one bit per enabled cycle until its MSB is set, and counts the shifts.
// A zero operand never shifts and raises its zero flag instead.
module approx_mult_engine_lod_normalizer
    import approx_mult_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = SH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] opnd,
    output logic [CNT_W-1:0]  cnt,
    output logic              zero,
    output logic              need_shift
);

    logic [DATA_W-1:0] opnd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              zero_r;
    logic              need_shift_s;

    // A nonzero operand whose MSB is still clear is not yet normalised.
    assign need_shift_s = (opnd_r != {DATA_W{1'b0}}) && !opnd_r[DATA_W-1];

    // Operand register, shift counter and zero flag; load has priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_r <= {DATA_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            zero_r <= 1'b0;
        end else if (load) begin
            opnd_r <= load_val;
            cnt_r  <= {CNT_W{1'b0}};
            zero_r <= (load_val == {DATA_W{1'b0}});
        end else if (en && need_shift_s) begin
            opnd_r <= {opnd_r[DATA_W-2:0], 1'b0};
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            zero_r <= zero_r;
        end else begin
            opnd_r <= opnd_r;
            cnt_r  <= cnt_r;
            zero_r <= zero_r;
        end
    end

    assign opnd       = opnd_r;
    assign cnt        = cnt_r;
    assign zero       = zero_r;
    assign need_shift = need_shift_s;

endmodule

// File: rtl/approx_mult_engine.sv
// Approximate / exact multiplier engine. Reads N_PAIRS operand pairs from a
// synchronous-read RAM (A at 2i, B at 2i+1), multiplies each pair either
// exactly or by leading-one truncation to SEG_W bits, and writes the
// 2*DATA_W-bit products to result address i. Outputs are registered from the
// next-state decode, so they behave as pure Moore outputs of the current state.
module approx_mult_engine
    import approx_mult_engine_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SEG_W   = 8,
    parameter int ADDR_W  = 5,
    parameter int N_PAIRS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    approx_mult_engine_if.master bus
);

    localparam int CNT_W = calc_sh_w(DATA_W);
    localparam int EXP_W = CNT_W + 2;
    localparam int P_W   = 2 * DATA_W;

    localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(N_PAIRS - 1);
    localparam logic [ADDR_W-1:0]       IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W-1:0] E_BASE   = EXP_W'(2 * (DATA_W - SEG_W));
    localparam logic signed [EXP_W-1:0] E_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};

    // FSM and datapath state
    logic [3:0]              state_r,  state_nxt;
    logic [ADDR_W-1:0]       i_r,      i_nxt;
    logic                    mode_r,   mode_nxt;
    logic [P_W-1:0]          acc_r,    acc_nxt;
    logic signed [EXP_W-1:0] e_r,      e_nxt;

    // Registered outputs
    logic                    rd_en_r;
    logic [ADDR_W-1:0]       rd_addr_r;
    logic                    wr_en_r;
    logic [ADDR_W-1:0]       wr_addr_r;
    logic [P_W-1:0]          wr_data_r;
    logic                    busy_r;
    logic                    done_r;

    // Normaliser hookup
    logic                    load_a_s, load_b_s, norm_en_s;
    logic [DATA_W-1:0]       opnd_a_s, opnd_b_s;
    logic [CNT_W-1:0]        cnt_a_s,  cnt_b_s;
    logic                    zero_a_s, zero_b_s;
    logic                    need_a_s, need_b_s;

    // Arithmetic
    logic [SEG_W-1:0]        seg_a_s,  seg_b_s;
    logic [2*SEG_W-1:0]      seg_prod_s;
    logic [P_W-1:0]          exact_prod_s;
    logic signed [EXP_W-1:0] e_calc_s;

    approx_mult_engine_lod_normalizer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lod_a (
        .clk        (clk),
        .rst        (rst),
        .load       (load_a_s),
        .en         (norm_en_s),
        .load_val   (bus.rd_data),
        .opnd       (opnd_a_s),
        .cnt        (cnt_a_s),
        .zero       (zero_a_s),
        .need_shift (need_a_s)
    );

    approx_mult_engine_lod_normalizer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lod_b (
        .clk        (clk),
        .rst        (rst),
        .load       (load_b_s),
        .en         (norm_en_s),
        .load_val   (bus.rd_data),
        .opnd       (opnd_b_s),
        .cnt        (cnt_b_s),
        .zero       (zero_b_s),
        .need_shift (need_b_s)
    );

    // Top SEG_W bits of the normalised operands; the exponent compensates
    // for both the normalising shifts and the dropped low bits.
    assign seg_a_s      = opnd_a_s[DATA_W-1 -: SEG_W];
    assign seg_b_s      = opnd_b_s[DATA_W-1 -: SEG_W];
    assign seg_prod_s   = {{SEG_W{1'b0}}, seg_a_s} * {{SEG_W{1'b0}}, seg_b_s};
    assign exact_prod_s = {{DATA_W{1'b0}}, opnd_a_s} * {{DATA_W{1'b0}}, opnd_b_s};
    assign e_calc_s     = E_BASE - $signed({2'b00, cnt_a_s}) - $signed({2'b00, cnt_b_s});

    // Next-state, pair index, mode, accumulator and exponent logic.
    always_comb begin
        state_nxt = state_r;
        i_nxt     = i_r;
        mode_nxt  = mode_r;
        acc_nxt   = acc_r;
        e_nxt     = e_r;
        load_a_s  = 1'b0;
        load_b_s  = 1'b0;
        norm_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_nxt  = bus.exact_mode;
                    i_nxt     = {ADDR_W{1'b0}};
                    state_nxt = ST_RD_A;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_A: begin
                state_nxt = ST_RD_B;
            end
            ST_RD_B: begin
                load_a_s  = 1'b1;
                state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                load_b_s  = 1'b1;
                state_nxt = mode_r ? ST_MUL : ST_NORM;
            end
            ST_NORM: begin
                norm_en_s = 1'b1;
                if (!need_a_s && !need_b_s) begin
                    state_nxt = ST_MUL;
                end else begin
                    state_nxt = ST_NORM;
                end
            end
            ST_MUL: begin
                if (mode_r) begin
                    acc_nxt   = exact_prod_s;
                    e_nxt     = {EXP_W{1'b0}};
                    state_nxt = ST_WR;
                end else if (zero_a_s || zero_b_s) begin
                    acc_nxt   = {P_W{1'b0}};
                    e_nxt     = {EXP_W{1'b0}};
                    state_nxt = ST_DENORM;
                end else begin
                    acc_nxt   = {{(P_W-2*SEG_W){1'b0}}, seg_prod_s};
                    e_nxt     = e_calc_s;
                    state_nxt = ST_DENORM;
                end
            end
            ST_DENORM: begin
                // Left shifts cannot overflow: the approximation never exceeds the exact product.
                if (e_r[EXP_W-1]) begin
                    acc_nxt = {1'b0, acc_r[P_W-1:1]};
                    e_nxt   = e_r + E_ONE;
                end else if (e_r != {EXP_W{1'b0}}) begin
                    acc_nxt = {acc_r[P_W-2:0], 1'b0};
                    e_nxt   = e_r - E_ONE;
                end else begin
                    state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                if (i_r == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    i_nxt     = i_r + IDX_ONE;
                    state_nxt = ST_RD_A;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            i_r     <= {ADDR_W{1'b0}};
            mode_r  <= 1'b0;
            acc_r   <= {P_W{1'b0}};
            e_r     <= {EXP_W{1'b0}};
        end else begin
            state_r <= state_nxt;
            i_r     <= i_nxt;
            mode_r  <= mode_nxt;
            acc_r   <= acc_nxt;
            e_r     <= e_nxt;
        end
    end

    // Output registers decoded from the upcoming state; addresses are zero while their strobe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {P_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            rd_en_r   <= (state_nxt == ST_RD_A) || (state_nxt == ST_RD_B);
            if (state_nxt == ST_RD_A) begin
                rd_addr_r <= {i_nxt[ADDR_W-2:0], 1'b0};
            end else if (state_nxt == ST_RD_B) begin
                rd_addr_r <= {i_nxt[ADDR_W-2:0], 1'b1};
            end else begin
                rd_addr_r <= {ADDR_W{1'b0}};
            end
            wr_en_r   <= (state_nxt == ST_WR);
            wr_addr_r <= (state_nxt == ST_WR) ? i_nxt : {ADDR_W{1'b0}};
            wr_data_r <= (state_nxt == ST_WR) ? acc_nxt : {P_W{1'b0}};
            busy_r    <= (state_nxt != ST_IDLE);
            done_r    <= (state_nxt == ST_DONE);
        end
    end

    assign bus.rd_en   = rd_en_r;
    assign bus.rd_addr = rd_addr_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_approx_mult_engine.sv
// Self-checking bench for approx_mult_engine: a default-parameter instance
// driven by a hand-computed vector table plus reset/start corner sequences,
// and a small-parameter instance driven by random operands against a
// behavioural model based on scaling each operand to its top SEG_W bits.
module tb_approx_mult_engine;

    localparam int DW  = 16;
    localparam int SW  = 8;
    localparam int AW  = 5;
    localparam int NP  = 8;
    localparam int DWS = 8;
    localparam int SWS = 4;
    localparam int AWS = 3;
    localparam int NPS = 4;
    localparam int BUDGET = 3000;

    typedef struct {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] exp_apx;
        logic [2*DW-1:0] exp_ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;
    vec_t vt [0:NP-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_mult_engine_if #(.DATA_W(DW),  .ADDR_W(AW))  bus_a ();
    approx_mult_engine_if #(.DATA_W(DWS), .ADDR_W(AWS)) bus_b ();

    approx_mult_engine #(.DATA_W(DW), .SEG_W(SW), .ADDR_W(AW), .N_PAIRS(NP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    approx_mult_engine #(.DATA_W(DWS), .SEG_W(SWS), .ADDR_W(AWS), .N_PAIRS(NPS)) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    // Synchronous-read RAMs
    logic [DW-1:0]  mem_a [0:(1<<AW)-1];
    logic [DWS-1:0] mem_b [0:(1<<AWS)-1];
    always @(posedge clk) if (bus_a.rd_en === 1'b1) bus_a.rd_data <= mem_a[bus_a.rd_addr];
    always @(posedge clk) if (bus_b.rd_en === 1'b1) bus_b.rd_data <= mem_b[bus_b.rd_addr];

    // Write / done monitors
    int              wa_cnt = 0, da_cnt = 0, da_cyc = 0, addr_viol = 0;
    int              wa_cyc  [$];
    logic [AW-1:0]   wa_addr [$];
    logic [2*DW-1:0] wa_data [$];
    int              wb_cnt = 0, db_cnt = 0;
    logic [AWS-1:0]  wb_addr [$];
    logic [2*DWS-1:0] wb_data [$];

    always @(negedge clk) begin
        if (bus_a.wr_en === 1'b1) begin
            wa_cnt++;
            wa_cyc.push_back(cyc);
            wa_addr.push_back(bus_a.wr_addr);
            wa_data.push_back(bus_a.wr_data);
        end
        if (bus_a.done === 1'b1) begin
            da_cnt++;
            da_cyc = cyc;
        end
        if (bus_b.wr_en === 1'b1) begin
            wb_cnt++;
            wb_addr.push_back(bus_b.wr_addr);
            wb_data.push_back(bus_b.wr_data);
        end
        if (bus_b.done === 1'b1) db_cnt++;
        if (mon_on && (((bus_a.rd_en !== 1'b1) && (bus_a.rd_addr !== '0)) ||
                       ((bus_a.wr_en !== 1'b1) && (bus_a.wr_addr !== '0)) ||
                       ((bus_b.rd_en !== 1'b1) && (bus_b.rd_addr !== '0)) ||
                       ((bus_b.wr_en !== 1'b1) && (bus_b.wr_addr !== '0))))
            addr_viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model
    function automatic int msb_pos(input longint unsigned x);
        int p = -1;
        for (int k = 0; k < 64; k++) if (x[k]) p = k;
        return p;
    endfunction

    function automatic longint unsigned top_bits(input longint unsigned x, input int sw);
        int l = msb_pos(x);
        return (l + 1 >= sw) ? (x >> (l + 1 - sw)) : (x << (sw - l - 1));
    endfunction

    // Product of the two operands each kept to its top sw significant bits,
    // scaled back to the operands' true magnitude with floor on the way down.
    function automatic longint unsigned ref_approx(input longint unsigned a, input longint unsigned b, input int sw);
        longint unsigned p;
        int e;
        if (a == 0 || b == 0) return 0;
        p = top_bits(a, sw) * top_bits(b, sw);
        e = (msb_pos(a) + 1 - sw) + (msb_pos(b) + 1 - sw);
        return (e >= 0) ? (p << e) : (p >> (-e));
    endfunction

    // Cycles from RD_A to WR inclusive for one pair.
    function automatic int ref_lat(input longint unsigned a, input longint unsigned b, input bit ex, input int dw, input int sw);
        int sa, sb, ns, e;
        if (ex) return 5;
        sa = (a == 0) ? 0 : dw - 1 - msb_pos(a);
        sb = (b == 0) ? 0 : dw - 1 - msb_pos(b);
        ns = (sa > sb) ? sa : sb;
        e  = (a == 0 || b == 0) ? 0 : msb_pos(a) + msb_pos(b) + 2 - 2 * sw;
        return 7 + ns + ((e < 0) ? -e : e);
    endfunction

    task automatic check_idle_a(input string tag);
        check({tag, "_strobes"}, {bus_a.rd_en, bus_a.wr_en, bus_a.busy, bus_a.done}, 4'b0000);
        check({tag, "_rd_addr"}, bus_a.rd_addr, '0);
        check({tag, "_wr_addr"}, bus_a.wr_addr, '0);
        check({tag, "_wr_data"}, bus_a.wr_data, '0);
    endtask

    task automatic clear_logs();
        wa_cyc.delete(); wa_addr.delete(); wa_data.delete();
        wb_addr.delete(); wb_data.delete();
        wa_cnt = 0; da_cnt = 0; wb_cnt = 0; db_cnt = 0;
    endtask

    // One full run of the table on the default instance.
    task automatic run_big(input bit ex);
        int  start_c, lat_sum, k;
        bit  got;
        @(negedge clk);
        clear_logs();
        bus_a.start = 1'b1;
        bus_a.exact_mode = ex;
        start_c = cyc;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.exact_mode = ~ex;
        #1;
        check($sformatf("busy_after_start_m%0d", ex), bus_a.busy, 1'b1);
        got = 1'b0;
        k = 0;
        while (!got && k < BUDGET) begin
            @(negedge clk); #1;
            if (da_cnt != 0) got = 1'b1;
            k++;
        end
        check($sformatf("done_seen_m%0d", ex), got, 1'b1);
        check($sformatf("busy_done_m%0d", ex), {bus_a.busy, bus_a.done}, 2'b11);
        check($sformatf("wr_count_m%0d", ex), wa_cnt, NP);
        lat_sum = start_c;
        for (int p = 0; p < NP; p++) begin
            lat_sum += ref_lat(vt[p].a, vt[p].b, ex, DW, SW);
            if (p < wa_data.size()) begin
                check($sformatf("wr_addr_m%0d_p%0d", ex, p), wa_addr[p], p);
                check($sformatf("wr_data_m%0d_p%0d", ex, p), wa_data[p], ex ? vt[p].exp_ex : vt[p].exp_apx);
                check($sformatf("wr_cycle_m%0d_p%0d", ex, p), wa_cyc[p], lat_sum);
            end
        end
        check($sformatf("done_cycle_m%0d", ex), da_cyc, lat_sum + 1);
        @(negedge clk); #1;
        check($sformatf("idle_after_done_m%0d", ex), {bus_a.busy, bus_a.done}, 2'b00);
        check($sformatf("done_count_m%0d", ex), da_cnt, 1);
    endtask

    // One run on the small instance with whatever mem_b holds.
    task automatic run_small(input bit ex, input int r);
        int k;
        longint unsigned a, b, exa, got_v, bound, ua, ub;
        @(negedge clk);
        clear_logs();
        bus_b.start = 1'b1;
        bus_b.exact_mode = ex;
        @(negedge clk);
        bus_b.start = 1'b0;
        k = 0;
        while (db_cnt == 0 && k < BUDGET) begin
            @(negedge clk); #1;
            k++;
        end
        check($sformatf("s_done_r%0d_m%0d", r, ex), db_cnt, 1);
        check($sformatf("s_wr_count_r%0d_m%0d", r, ex), wb_cnt, NPS);
        for (int p = 0; p < NPS && p < wb_data.size(); p++) begin
            a = mem_b[2*p];
            b = mem_b[2*p+1];
            exa = a * b;
            got_v = wb_data[p];
            check($sformatf("s_wr_addr_r%0d_m%0d_p%0d", r, ex, p), wb_addr[p], p);
            if (ex) begin
                check($sformatf("s_exact_r%0d_p%0d", r, p), got_v, exa);
            end else begin
                ua = (a != 0 && msb_pos(a) + 1 > SWS) ? (64'd1 << (msb_pos(a) + 1 - SWS)) : 64'd0;
                ub = (b != 0 && msb_pos(b) + 1 > SWS) ? (64'd1 << (msb_pos(b) + 1 - SWS)) : 64'd0;
                bound = ua * b + ub * a + 1;
                check($sformatf("s_approx_r%0d_p%0d", r, p), got_v, ref_approx(a, b, SWS));
                check($sformatf("s_le_exact_r%0d_p%0d", r, p), (got_v <= exa), 1'b1);
                check($sformatf("s_err_bound_r%0d_p%0d", r, p), ((exa - got_v) <= bound), 1'b1);
            end
        end
    endtask

    initial begin
        int k;
        vt[0] = '{16'h1234, 16'h0010, 32'h0001_2200, 32'h0001_2340};
        vt[1] = '{16'h0003, 16'h0005, 32'h0000_000F, 32'h0000_000F};
        vt[2] = '{16'hFFFF, 16'hFFFF, 32'hFE01_0000, 32'hFFFE_0001};
        vt[3] = '{16'h0001, 16'h0001, 32'h0000_0001, 32'h0000_0001};
        vt[4] = '{16'h0000, 16'hABCD, 32'h0000_0000, 32'h0000_0000};
        vt[5] = '{16'hABCD, 16'h0000, 32'h0000_0000, 32'h0000_0000};
        vt[6] = '{16'h8000, 16'h8000, 32'h4000_0000, 32'h4000_0000};
        vt[7] = '{16'h00FF, 16'h0100, 32'h0000_FF00, 32'h0000_FF00};
        for (int p = 0; p < (1 << AW); p++) mem_a[p] = '0;
        for (int p = 0; p < NP; p++) begin
            mem_a[2*p]   = vt[p].a;
            mem_a[2*p+1] = vt[p].b;
        end
        for (int p = 0; p < (1 << AWS); p++) mem_b[p] = '0;

        bus_a.start = 1'b0; bus_a.exact_mode = 1'b0;
        bus_b.start = 1'b0; bus_b.exact_mode = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_idle_a("reset");
        rst = 1'b0;
        mon_on = 1'b1;

        run_big(1'b0);
        run_big(1'b1);

        // start held high for a whole run: one done, then a fresh run from IDLE
        @(negedge clk);
        clear_logs();
        bus_a.start = 1'b1;
        bus_a.exact_mode = 1'b0;
        k = 0;
        while (da_cnt == 0 && k < BUDGET) begin
            @(negedge clk); #1;
            k++;
        end
        check("held_done_seen", da_cnt, 1);
        check("held_wr_count", wa_cnt, NP);
        @(negedge clk); #1;
        check("held_idle_gap", bus_a.busy, 1'b0);
        @(negedge clk); #1;
        check("held_restart", bus_a.busy, 1'b1);
        check("held_single_done", da_cnt, 1);
        bus_a.start = 1'b0;

        // reset in the DENORM phase of pair 3 (operands 1,1: 15 DENORM cycles)
        k = 0;
        while (wa_cnt < NP + 3 && k < BUDGET) begin
            @(negedge clk); #1;
            k++;
        end
        check("pre_rst_wr_count", wa_cnt, NP + 3);
        repeat (24) @(negedge clk);
        check("no_wr_before_rst", wa_cnt, NP + 3);
        rst = 1'b1;
        @(negedge clk); #1;
        check_idle_a("midrun_reset");
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no_wr_after_rst", wa_cnt, NP + 3);
        check("no_done_after_rst", da_cnt, 1);
        check("idle_after_rst", bus_a.busy, 1'b0);

        run_big(1'b1);

        // small instance, random operands
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 2 * NPS; p++) mem_b[p] = DWS'($urandom_range(0, 255));
            if (r == 0) mem_b[2] = '0;
            if (r == 1) begin
                mem_b[0] = 8'd1;
                mem_b[1] = 8'd3;
            end
            run_small(1'b0, r);
            run_small(1'b1, r);
        end

        check("addr_zero_when_idle", addr_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
